i_wr_fetch_ctrl: RTL and testbench

Frame-readout controller for the image write path. On start it walks a stored image in SRAM in raster order, one read per pixel, and presents each pixel downstream on a valid/ready stream. It runs the column/row counting that drives the column counter stage, and it generates the SRAM read address and the end-of-line and end-of-frame markers consumed by the image writer.

---
 rtl/i_wr_pkg.sv | 18 +
 rtl/flex_counter.sv | 40 ++++
 rtl/i_wr_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_i_wr_fetch_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_wr_pkg.sv
// Shared types and default widths for the image write-path readout controller.
// Contents: readout FSM state encoding; default address, pixel and dimension widths.
// Imported by i_wr_fetch_ctrl; flex_counter is self-contained and does not need it.
package i_wr_pkg;

  localparam int DEF_ADDR_W = 18;  // SRAM word address width
  localparam int DEF_PIX_W  = 24;  // RGB888 pixel / SRAM data width
  localparam int DEF_DIM_W  = 13;  // image width/height field width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable rollover: counts 0..rollover_val, then wraps to 0.
// Ports: clk, n_rst (async active-low), clear, count_enable, rollover_val in; count_out, rollover_flag out.
// rollover_flag is combinational and is high whenever count_out equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_enable) begin
      cnt_d = (cnt_q == rollover_val) ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_out     = cnt_q;
  assign rollover_flag = (cnt_q == rollover_val);

endmodule

// File: rtl/i_wr_fetch_ctrl.sv
// Frame readout controller: walks a stored image in SRAM in raster order, one read per pixel,
// and streams each pixel downstream on a valid/ready handshake with eol/eof and col/row tags.
// Ports: start/base_addr/img_width/img_height in; sram_rd_en/sram_addr out, sram_rd_data in;
//        pix_out/pix_valid/eol/eof/col_idx/row_idx out, pix_ready in; busy/done status out.
module i_wr_fetch_ctrl
  import i_wr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [PIX_W-1:0]  sram_rd_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              eol,
  output logic              eof,
  output logic [DIM_W-1:0]  col_idx,
  output logic [DIM_W-1:0]  row_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [PIX_W-1:0]  pix_q;
  logic              vld_q, eol_q, eof_q;

  logic              start_ok;
  logic              hs;
  logic              last_col, last_row;
  logic [DIM_W-1:0]  col_cnt, row_cnt;

  assign start_ok = (state_q == IDLE) && start;
  assign hs       = (state_q == OUT) && vld_q && pix_ready;

  // Column wraps at width-1 on every accepted pixel; row advances only on the
  // last pixel of a line. Both clear when a frame is accepted.
  flex_counter #(.NUM_CNT_BITS(DIM_W)) u_col_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start_ok),
    .count_enable (hs),
    .rollover_val (width_q - DIM_ONE),
    .count_out    (col_cnt),
    .rollover_flag(last_col)
  );

  flex_counter #(.NUM_CNT_BITS(DIM_W)) u_row_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (start_ok),
    .count_enable (hs && eol_q),
    .rollover_val (height_q - DIM_ONE),
    .count_out    (row_cnt),
    .rollover_flag(last_row)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Degenerate frames skip straight to DONE without touching SRAM.
          state_d = ((img_width == '0) || (img_height == '0)) ? DONE : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT:  state_d = OUT;
      OUT: begin
        if (hs) begin
          state_d = eof_q ? DONE : ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      pix_q    <= '0;
      vld_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q   <= base_addr;
        width_q  <= img_width;
        height_q <= img_height;
      end
      // Read data is valid the cycle after ISSUE, i.e. while in WAIT.
      if (state_q == WAIT) begin
        pix_q <= sram_rd_data;
        vld_q <= 1'b1;
        eol_q <= last_col;
        eof_q <= last_col && last_row;
      end
      if (hs) begin
        vld_q  <= 1'b0;
        eol_q  <= 1'b0;
        eof_q  <= 1'b0;
        addr_q <= addr_q + ADDR_ONE;  // raster order == linear address order
      end
    end
  end

  assign sram_rd_en = (state_q == ISSUE);
  assign sram_addr  = addr_q;
  assign pix_out    = pix_q;
  assign pix_valid  = vld_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign col_idx    = col_cnt;
  assign row_idx    = row_cnt;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_i_wr_fetch_ctrl.sv
module tb_i_wr_fetch_ctrl;

  localparam int AW = 18;
  localparam int PW = 24;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] img_width = '0;
  logic [DW-1:0] img_height = '0;
  logic          sram_rd_en;
  logic [AW-1:0] sram_addr;
  logic [PW-1:0] sram_rd_data = '0;
  logic [PW-1:0] pix_out;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic          eol, eof;
  logic [DW-1:0] col_idx, row_idx;
  logic          busy, done;

  i_wr_fetch_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start(start), .base_addr(base_addr),
    .img_width(img_width), .img_height(img_height),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rd_data(sram_rd_data),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .eol(eol), .eof(eof), .col_idx(col_idx), .row_idx(row_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pix;
    logic          eol;
    logic          eof;
    logic [DW-1:0] col;
    logic [DW-1:0] row;
  } exp_t;

  exp_t          pq[$];
  logic [AW-1:0] aq[$];
  int            done_at[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            rdy_mode = 0;
  int            hold_cnt = 0;

  function automatic logic [PW-1:0] memf(input logic [AW-1:0] a);
    return {a[5:0], a} ^ 24'hA5C35A;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(sram_rd_en), 0);
    chk({tag, "_addr"},  32'(sram_addr), 0);
    chk({tag, "_pix"},   32'(pix_out), 0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_eol"},   32'(eol), 0);
    chk({tag, "_eof"},   32'(eof), 0);
    chk({tag, "_col"},   32'(col_idx), 0);
    chk({tag, "_row"},   32'(row_idx), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  // SRAM model: data appears one cycle after the read strobe; otherwise poison.
  always @(posedge clk) begin
    sram_rd_data <= sram_rd_en ? memf(sram_addr) : 24'hBAD0BA;
  end

  always @(posedge clk) cyc++;

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = 1'($urandom_range(0, 1));
        default: begin
          if (pix_valid && hold_cnt < 5) begin
            hold_cnt++;
            pix_ready = 1'b0;
          end else begin
            pix_ready = (hold_cnt >= 5);
          end
        end
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic          stall_prev;
    logic [PW-1:0] pix_prev;
    logic          eol_prev, eof_prev;
    logic [DW-1:0] col_prev, row_prev;
    stall_prev = 1'b0;
    pix_prev = '0; eol_prev = 0; eof_prev = 0; col_prev = '0; row_prev = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (sram_rd_en) begin
        chk("rd_expected", 32'(aq.size() > 0), 1);
        chk("rd_one_outstanding", 32'(pix_valid), 0);
        if (aq.size() > 0) chk("rd_addr", 32'(sram_addr), 32'(aq.pop_front()));
      end
      begin
        logic exp_done;
        exp_done = (done_at.size() > 0) && (done_at[0] == cyc);
        if (exp_done) void'(done_at.pop_front());
        chk("done", 32'(done), 32'(exp_done));
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(pix_valid), 1);
        chk("stall_pix", 32'(pix_out), 32'(pix_prev));
        chk("stall_eol", 32'(eol), 32'(eol_prev));
        chk("stall_eof", 32'(eof), 32'(eof_prev));
        chk("stall_col", 32'(col_idx), 32'(col_prev));
        chk("stall_row", 32'(row_idx), 32'(row_prev));
      end
      stall_prev = pix_valid && !pix_ready;
      pix_prev = pix_out; eol_prev = eol; eof_prev = eof; col_prev = col_idx; row_prev = row_idx;
      if (pix_valid && pix_ready) begin
        chk("pix_expected", 32'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          exp_t e;
          e = pq.pop_front();
          chk("pix_data", 32'(pix_out), 32'(e.pix));
          chk("pix_eol", 32'(eol), 32'(e.eol));
          chk("pix_eof", 32'(eof), 32'(e.eof));
          chk("pix_col", 32'(col_idx), 32'(e.col));
          chk("pix_row", 32'(row_idx), 32'(e.row));
          if (e.eof) done_at.push_back(cyc + 1);
        end
      end
    end
  end

  // Reference model: a w x h frame at base reads base + r*w + c in raster order.
  task automatic push_frame(input logic [AW-1:0] b, input int w, input int h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        exp_t e;
        logic [AW-1:0] a;
        a = AW'((int'(b) + r * w + c) % (1 << AW));
        aq.push_back(a);
        e.pix = memf(a);
        e.eol = (c == w - 1);
        e.eof = (c == w - 1) && (r == h - 1);
        e.col = DW'(c);
        e.row = DW'(r);
        pq.push_back(e);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= 3000), 0);
  endtask

  task automatic run_frame(input string tag, input logic [AW-1:0] b, input int w,
                           input int h, input int mode, input bit mid);
    rdy_mode = mode;
    hold_cnt = 0;
    push_frame(b, w, h);
    base_addr = b;
    img_width = DW'(w);
    img_height = DW'(h);
    if (w == 0 || h == 0) done_at.push_back(cyc + 1);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy), 1);
    if (mid) begin
      repeat (4) @(posedge clk);
      #2;
      base_addr = 18'h2AAAA;
      img_width = 13'd7;
      img_height = 13'd9;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
    end
    wait_idle(tag);
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_pix_left"}, 32'(pq.size()), 0);
    chk({tag, "_rd_left"}, 32'(aq.size()), 0);
    chk({tag, "_done_left"}, 32'(done_at.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    n_rst = 1'b0;
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #2;

    run_frame("f3x2", 18'h00100, 3, 2, 0, 1'b0);
    run_frame("bp2x1", 18'h01234, 2, 1, 2, 1'b0);
    run_frame("w0", 18'h00200, 0, 4, 0, 1'b0);
    run_frame("h0", 18'h00300, 5, 0, 1, 1'b0);
    run_frame("mid", 18'h00400, 4, 3, 1, 1'b1);
    run_frame("wrap", 18'h3FFFE, 4, 1, 0, 1'b0);
    run_frame("one", 18'h15555, 1, 1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run_frame("rnd", AW'($urandom), int'($urandom_range(1, 5)),
                int'($urandom_range(1, 4)), 1, 1'b0);
    end

    // Abort mid-frame while pixel 3 (col 0, row 1) is presented.
    rdy_mode = 0;
    push_frame(18'h00800, 3, 2);
    base_addr = 18'h00800;
    img_width = 13'd3;
    img_height = 13'd2;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    while (!(pix_valid && col_idx == 0 && row_idx == 1) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("abort_reach_px3", 32'(n >= 100), 0);
    n_rst = 1'b0;
    #1;
    chk_all_zero("abort");
    pq.delete();
    aq.delete();
    done_at.delete();
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    run_frame("restart", 18'h00800, 3, 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
